// File: rtl/uart_pkg.sv
// Shared UART link types: command packet layout and opcodes.
// Used by both the receive framer and the response transmitter.
package uart_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [7:0] OPC_READ  = 8'h52;
  localparam logic [7:0] OPC_WRITE = 8'h57;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic logic opc_ok(input logic [7:0] b);
    return (b == OPC_READ) || (b == OPC_WRITE);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser plus oversampled bit FSM.
// Emits a 1-clk byte_valid on a good stop bit, stop_err otherwise.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_16x,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  rx_state_t     state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic          rx_meta;
  logic          rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RX_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      if (baud_tick_16x) begin
        unique case (state)
          RX_IDLE: begin
            if (!rx_s) begin
              state    <= RX_START;
              tick_cnt <= '0;
            end
          end
          RX_START: begin
            if (tick_cnt == MID) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              rx_byte  <= {rx_s, rx_byte[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7)
                state <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                byte_valid <= 1'b1;
                state      <= RX_IDLE;
              end else begin
                stop_err <= 1'b1;
                state    <= RX_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          RX_BREAK: begin
            if (rx_s)
              state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_rx_cmd_framer.sv
// UART command receiver: assembles {opcode, addr, data} frames
// from received bytes and pushes them into the command FIFO.
module uart_rx_cmd_framer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_TICKS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick_16x,
  input  logic        rx,
  output cmd_packet_t cmd_fifo_wr_data,
  output logic        cmd_fifo_wr_en,
  input  logic        cmd_fifo_full,
  output logic        frame_err,
  output logic        overflow_err
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          stop_err;
  logic [1:0]    idx;
  logic [7:0]    opc_q;
  logic [7:0]    addr_q;
  logic [TW-1:0] to_cnt;

  uart_rx_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx_byte (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_16x(baud_tick_16x),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .stop_err     (stop_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx              <= '0;
      opc_q            <= '0;
      addr_q           <= '0;
      to_cnt           <= '0;
      cmd_fifo_wr_data <= '0;
      cmd_fifo_wr_en   <= 1'b0;
      frame_err        <= 1'b0;
      overflow_err     <= 1'b0;
    end else begin
      cmd_fifo_wr_en <= 1'b0;
      frame_err      <= 1'b0;
      overflow_err   <= 1'b0;
      if (stop_err) begin
        frame_err <= 1'b1;
        idx       <= '0;
        to_cnt    <= '0;
      end else if (byte_valid) begin
        to_cnt <= '0;
        unique case (idx)
          2'd0: begin
            if (opc_ok(rx_byte)) begin
              opc_q <= rx_byte;
              idx   <= 2'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          2'd1: begin
            addr_q <= rx_byte;
            idx    <= 2'd2;
          end
          default: begin
            idx <= '0;
            if (cmd_fifo_full) begin
              overflow_err <= 1'b1;
            end else begin
              cmd_fifo_wr_en   <= 1'b1;
              cmd_fifo_wr_data <= '{opc_q, addr_q, rx_byte};
            end
          end
        endcase
      end else if (idx == 2'd0) begin
        to_cnt <= '0;
      end else if (baud_tick_16x) begin
        // a stalled partial frame is dropped rather than merged with later bytes
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          idx       <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_framer.sv
// Bench for uart_rx_cmd_framer: frame-level model plus
// directed serial stimulus and literal spot checks.
module tb_uart_rx_cmd_framer;
  import uart_pkg::*;

  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        rx = 1'b1;
  logic        full = 1'b0;
  cmd_packet_t wr_data;
  logic        wr_en;
  logic        ferr;
  logic        ovf;

  uart_rx_cmd_framer dut (
    .clk             (clk),
    .rst             (rst),
    .baud_tick_16x   (tick),
    .rx              (rx),
    .cmd_fifo_wr_data(wr_data),
    .cmd_fifo_wr_en  (wr_en),
    .cmd_fifo_full   (full),
    .frame_err       (ferr),
    .overflow_err    (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  typedef enum int {EV_PUSH, EV_FERR, EV_OVF} ev_kind_e;
  typedef struct {
    ev_kind_e    k;
    logic [23:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] part[$];

  int          tests = 0;
  int          fails = 0;
  int          n_push = 0;
  int          n_ferr = 0;
  int          n_ovf = 0;
  logic [23:0] last_push = '0;
  int          last_push_cyc = 0;
  int          stop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.d = '0;
    if (!stop_ok) begin
      e.k = EV_FERR;
      exp_q.push_back(e);
      part.delete();
    end else if (part.size() == 0 && b != 8'h52 && b != 8'h57) begin
      e.k = EV_FERR;
      exp_q.push_back(e);
    end else begin
      part.push_back(b);
      if (part.size() == 3) begin
        e.k = full ? EV_OVF : EV_PUSH;
        e.d = full ? 24'h0 : {part[0], part[1], part[2]};
        exp_q.push_back(e);
        part.delete();
      end
    end
  endfunction

  function automatic void model_timeout();
    ev_t e;
    if (part.size() != 0) begin
      e.k = EV_FERR;
      e.d = '0;
      exp_q.push_back(e);
      part.delete();
    end
  endfunction

  always @(negedge clk) begin
    ev_t      ev;
    ev_kind_e act;
    if (rst && (wr_en || ferr || ovf)) begin
      check("exclusive_pulse", 32'(int'(wr_en) + int'(ferr) + int'(ovf)), 1);
      act = wr_en ? EV_PUSH : (ferr ? EV_FERR : EV_OVF);
      if (wr_en) begin
        n_push++;
        last_push = wr_data;
        last_push_cyc = cyc;
      end
      if (ferr) n_ferr++;
      if (ovf) n_ovf++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(act) + 1, 0);
      end else begin
        ev = exp_q.pop_front();
        check("event_kind", 32'(act), 32'(ev.k));
        if (wr_en)
          check("wr_data", 32'(wr_data), 32'(ev.d));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    model_byte(b, stop_ok);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    stop_cyc = cyc;
    rx = stop_ok;
    wait_clks(BIT);
    if (!stop_ok) begin
      rx = 1'b1;
      wait_clks(BIT);
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    wait_clks(nbits * BIT);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_wr_en"}, 32'(wr_en), 0);
    check({name, "_ferr"}, 32'(ferr), 0);
    check({name, "_ovf"}, 32'(ovf), 0);
    check({name, "_wr_data"}, 32'(wr_data), 0);
  endtask

  initial begin
    wait_clks(5);
    check_quiet("reset");
    rst = 1'b1;
    idle(2);

    send3(8'h57, 8'h10, 8'hA5);
    idle(2);
    check("t1_push_cnt", 32'(n_push), 1);
    check("t1_data", 32'(last_push), 32'h5710A5);
    check("t1_latency", 32'((last_push_cyc - stop_cyc) inside {[30:44]}), 1);

    send3(8'h52, 8'h22, 8'h00);
    send3(8'h57, 8'h23, 8'h5A);
    idle(2);
    check("t2_push_cnt", 32'(n_push), 3);
    check("t2_data", 32'(last_push), 32'h57235A);
    check("t2_no_err", 32'(n_ferr + n_ovf), 0);

    send_byte(8'h57, 1'b0);
    idle(1);
    send3(8'h57, 8'h10, 8'hA5);
    idle(2);
    check("t3_ferr_cnt", 32'(n_ferr), 1);
    check("t3_push_cnt", 32'(n_push), 4);
    check("t3_data", 32'(last_push), 32'h5710A5);

    rx = 1'b0;
    wait_clks(16);
    idle(2);
    check("t4_glitch_no_err", 32'(n_ferr), 1);
    send_byte(8'h41);
    idle(1);
    check("t4_bad_opc", 32'(n_ferr), 2);
    send3(8'h52, 8'h01, 8'h00);
    idle(2);
    check("t4_push_cnt", 32'(n_push), 5);
    check("t4_data", 32'(last_push), 32'h520100);

    send_byte(8'h57);
    send_byte(8'h10);
    model_timeout();
    rx = 1'b1;
    wait_clks(2100 * 4);
    check("t5_timeout", 32'(n_ferr), 3);
    send3(8'h57, 8'h11, 8'h33);
    idle(2);
    check("t5_push_cnt", 32'(n_push), 6);
    check("t5_data", 32'(last_push), 32'h571133);

    full = 1'b1;
    send3(8'h57, 8'h10, 8'hA5);
    idle(2);
    full = 1'b0;
    check("t6_ovf_cnt", 32'(n_ovf), 1);
    check("t6_no_push", 32'(n_push), 6);
    send_byte(8'h57);
    rx = 1'b0;
    wait_clks(3 * BIT);
    rst = 1'b0;
    rx = 1'b1;
    part.delete();
    wait_clks(3);
    check_quiet("midreset");
    rst = 1'b1;
    idle(2);
    send3(8'h57, 8'h10, 8'hA5);
    idle(2);
    check("t6_push_cnt", 32'(n_push), 7);
    check("t6_data", 32'(last_push), 32'h5710A5);
    check("t6_ferr_cnt", 32'(n_ferr), 3);
    check("model_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
